// File: rtl/ahb_cfg_pkg.sv
// Shared types and beat program for the AHB-Lite configuration master.
// AHB_CFG_READBACK_EN appends a data_size readback beat.
package ahb_cfg_pkg;

  localparam logic [2:0] ERR_STATUS_ADDRESS = 3'd1;
  localparam logic [2:0] PAYLOAD_ADDRESS    = 3'd2;
  localparam logic [2:0] DATA_SIZE_ADDRESS  = 3'd4;
  localparam logic [2:0] BYTE_HSIZE         = 3'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_LAST_DATA,
    S_ERR2
  } state_t;

`ifdef AHB_CFG_READBACK_EN
  localparam int unsigned NUM_BEATS = 5;
  localparam logic [2:0]  SIZE_BEAT = 3'd4;
`else
  localparam int unsigned NUM_BEATS = 4;
`endif

  localparam logic [2:0] LAST_BEAT = 3'(NUM_BEATS - 1);
  localparam logic [2:0] ERR_BEAT  = 3'd3;

  typedef struct packed {
    logic [2:0] addr;
    logic       write;
    logic [7:0] data;
  } beat_t;

  function automatic beat_t beat_lookup(
    input logic [2:0]  index,
    input logic [7:0]  size,
    input logic [15:0] payload
  );
    beat_t b;
    b = '0;
    case (index)
      3'd0: b = '{addr: DATA_SIZE_ADDRESS,
                  write: 1'b1, data: size};
      3'd1: b = '{addr: PAYLOAD_ADDRESS,
                  write: 1'b1, data: payload[7:0]};
      3'd2: b = '{addr: PAYLOAD_ADDRESS + 3'd1,
                  write: 1'b1, data: payload[15:8]};
      3'd3: b = '{addr: ERR_STATUS_ADDRESS,
                  write: 1'b0, data: 8'h00};
`ifdef AHB_CFG_READBACK_EN
      3'd4: b = '{addr: DATA_SIZE_ADDRESS,
                  write: 1'b0, data: 8'h00};
`endif
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ahb_cfg_master.sv
// Pipelined AHB-Lite master that programs the packet register slave.
// Build with AHB_CFG_READBACK_EN to add the data_size readback check.
module ahb_cfg_master
  import ahb_cfg_pkg::*;
(
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        start,
  input  logic [4:0]  req_data_size,
  input  logic [15:0] req_payload,
  output logic        busy,
  output logic        done,
  output logic        bus_err,
  output logic [1:0]  err_out,
`ifdef AHB_CFG_READBACK_EN
  output logic        size_mismatch,
`endif
  output logic [2:0]  haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [7:0]  hwdata,
  input  logic [7:0]  hrdata,
  input  logic        hready,
  input  logic        hresp
);

  state_t      state;
  logic [2:0]  beat_q;
  logic        d_active;
  logic [2:0]  d_idx;
  logic [4:0]  size_q;
  logic [15:0] payload_q;
  logic [7:0]  wdata_q;

  beat_t       nxt;
  logic        d_ok;
  logic        d_err;
  logic        unused_ok;

  assign d_ok      = d_active & hready;
  assign d_err     = d_active & hresp & ~hready;
  assign unused_ok = ^hrdata;

  // While idle the table is fed from the request so beat0 launches at start
  always_comb begin
    nxt = '0;
    if (state == S_IDLE)
      nxt = beat_lookup(3'd0, {3'b0, req_data_size},
                        req_payload);
    else
      nxt = beat_lookup(beat_q + 3'd1, {3'b0, size_q},
                        payload_q);
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state     <= S_IDLE;
      beat_q    <= '0;
      d_active  <= 1'b0;
      d_idx     <= '0;
      size_q    <= '0;
      payload_q <= '0;
      wdata_q   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bus_err   <= 1'b0;
      err_out   <= '0;
`ifdef AHB_CFG_READBACK_EN
      size_mismatch <= 1'b0;
`endif
      htrans    <= IDLE;
      haddr     <= '0;
      hwrite    <= 1'b0;
      hsize     <= '0;
      hwdata    <= '0;
    end else begin
      done <= 1'b0;

      if (d_ok) begin
        if (d_idx == ERR_BEAT)
          err_out <= hrdata[1:0];
`ifdef AHB_CFG_READBACK_EN
        if (d_idx == SIZE_BEAT)
          size_mismatch <= hrdata[4:0] != size_q;
`endif
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ADDR;
            busy      <= 1'b1;
            bus_err   <= 1'b0;
            size_q    <= req_data_size;
            payload_q <= req_payload;
            beat_q    <= '0;
            d_active  <= 1'b0;
            htrans    <= NONSEQ;
            haddr     <= nxt.addr;
            hwrite    <= nxt.write;
            hsize     <= BYTE_HSIZE;
            wdata_q   <= nxt.data;
          end
        end

        S_ADDR: begin
          if (d_err) begin
            state    <= S_ERR2;
            d_active <= 1'b0;
            htrans   <= IDLE;
            haddr    <= '0;
            hwrite   <= 1'b0;
            hsize    <= '0;
          end else if (hready) begin
            d_active <= 1'b1;
            d_idx    <= beat_q;
            if (hwrite)
              hwdata <= wdata_q;
            if (beat_q == LAST_BEAT) begin
              state  <= S_LAST_DATA;
              htrans <= IDLE;
              haddr  <= '0;
              hwrite <= 1'b0;
              hsize  <= '0;
            end else begin
              beat_q  <= beat_q + 3'd1;
              htrans  <= NONSEQ;
              haddr   <= nxt.addr;
              hwrite  <= nxt.write;
              hsize   <= BYTE_HSIZE;
              wdata_q <= nxt.data;
            end
          end
        end

        S_LAST_DATA: begin
          if (d_err) begin
            state    <= S_ERR2;
            d_active <= 1'b0;
          end else if (hready) begin
            state    <= S_IDLE;
            d_active <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end

        S_ERR2: begin
          if (hready) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            bus_err <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
